// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - two-wide instruction fetch sequencer with bundle queue and redirect squash
module fetch_sequencer #(
    parameter int          DEPTH    = 4,
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] NOP_INST = 16'hFFFF
) (
    input  logic        clock,
    input  logic        reset,
    output logic [15:0] mem_address,
    input  logic [31:0] inst_bus,
    input  logic        fetch_en,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_inst0,
    output logic [15:0] out_inst1,
    output logic [1:0]  out_slot_valid,
    output logic [15:0] out_pc,
    output logic [3:0]  queue_count
);

    localparam int         PTR_W   = $clog2(DEPTH);
    localparam logic [3:0] DEPTH_C = 4'(DEPTH);

    logic [15:0]      pc;
    logic             squash;
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [3:0]       count;

    logic [15:0] q_inst0 [DEPTH];
    logic [15:0] q_inst1 [DEPTH];
    logic [15:0] q_pc    [DEPTH];
    logic [1:0]  q_slot  [DEPTH];

    logic push;
    logic pop;

    assign mem_address = pc;
    assign queue_count = count;
    assign out_valid   = (count != 4'd0);

    // A redirect suppresses both queue operations; a full queue may still accept a push when it pops.
    assign pop  = out_valid && out_ready && !redirect_valid;
    assign push = reset && fetch_en && !redirect_valid && ((count < DEPTH_C) || pop);

    always_ff @(posedge clock) begin
        if (!reset) begin
            pc     <= RESET_PC;
            squash <= 1'b0;
            head   <= '0;
            tail   <= '0;
            count  <= 4'd0;
        end else if (redirect_valid) begin
            pc     <= {redirect_pc[15:1], 1'b0};
            squash <= redirect_pc[0];
            head   <= '0;
            tail   <= '0;
            count  <= 4'd0;
        end else begin
            if (push) begin
                tail   <= tail + 1'b1;
                pc     <= pc + 16'd2;
                squash <= 1'b0;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 4'd1;
            end else if (pop && !push) begin
                count <= count - 4'd1;
            end
        end
    end

    // Odd redirect target: the even-address slot precedes the target and is replaced by a NOP.
    always_ff @(posedge clock) begin
        if (push) begin
            q_inst0[tail] <= squash ? NOP_INST : inst_bus[31:16];
            q_inst1[tail] <= inst_bus[15:0];
            q_pc[tail]    <= pc;
            q_slot[tail]  <= squash ? 2'b10 : 2'b11;
        end
    end

    always_comb begin
        out_inst0      = NOP_INST;
        out_inst1      = NOP_INST;
        out_pc         = 16'h0000;
        out_slot_valid = 2'b00;
        if (reset && out_valid) begin
            out_inst0      = q_inst0[head];
            out_inst1      = q_inst1[head];
            out_pc         = q_pc[head];
            out_slot_valid = q_slot[head];
        end
    end

endmodule
